alu_md_control: RTL and testbench
=================================

Name: alu_md_control

Overview:
- Parametrised successor to the single-cycle ALU control.
- Decodes aluop/func3/func7 into a 4-bit ALU operation code, as before, and adds RV32M support (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- M-extension ops run on an iterative multiply/divide engine with a start/busy/done handshake.
- Sits between the control unit / register file and the ALU result mux. The stall output holds the PC while the engine runs.

Parameters:
- WIDTH, 32, operand and result width in bits (≥4, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.
- R_ALUOP, 3'b111, aluop value marking R-type.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- aluop  in  3  ALU op class from the control unit.
- func3  in  3  instr[14:12].
- func7  in  7  instr[31:25].
- start  in  1  issue strobe; qualifies an M op in the current instruction.
- operand_a  in  WIDTH  rs1 value.
- operand_b  in  WIDTH  rs2 value.
- aluoperation  out  4  ALU operation code.
- md_busy  out  1  engine running.
- md_done  out  1  one-cycle result-valid pulse.
- md_result  out  WIDTH  M-op result, held until the next accepted start.
- md_stall  out  1  PC/pipeline hold request.

Behaviour:
- Decode is combinational, with fixed codes:
  - R-type (aluop=R_ALUOP), func7=0000000: f3 000→0000 add, 111→0001 and, 110→0100 or, 001→0101 sll, 101→0110 srl, 100→1001 xor.
  - R-type, func7=0100000 with f3 000→0111 sub.
  - R-type, func7=0000001 (any f3)→1000, select md_result.
  - Non-R aluop: 000→0000 (addi/lw/sw), 001→0001 (andi), 100→0010 (lui), 101→0100 (ori), 010/011→0111 (beq/bne).
  - Anything else→1111.
- md_op = (aluop==R_ALUOP) & (func7==0000001).
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start & md_op: latch func3, operand signs and magnitudes; signedness per op (MULHSU: a signed, b unsigned; *U: both unsigned). Clear accumulator, set counter=WIDTH, go to CALC.
  - start without md_op: ignored.
- CALC: one iteration per cycle, counter decrements; on counter==1 go to FIX.
  - Multiply: shift-add on magnitudes into a 2*WIDTH product.
  - Divide: restoring; quotient and remainder each WIDTH bits.
- FIX: one cycle.
  - Negate the product if the signs differ.
  - Negate the quotient if the signs differ; negate the remainder if the dividend is negative.
  - Select the low half (MUL), high half (MULH*), quotient or remainder into md_result.
  - Go to DONE.
- DONE: md_done=1 for this cycle only; next state IDLE.
- Latency: md_done asserts exactly WIDTH+2 cycles after the cycle in which start was sampled. Back-to-back: a new start is accepted in the IDLE cycle following DONE.
- md_busy = state∈{CALC,FIX}.
- md_stall = (IDLE & start & md_op) | CALC | FIX. It is low in DONE, so the instruction retires with md_result.
- start while busy: ignored; latched operands and op are unchanged.
- Divide by zero:
  - Quotient = all ones (DIV and DIVU).
  - Remainder = dividend.
  - Normal latency, no exception.
- Signed overflow (DIV/REM, dividend = most-negative, divisor = −1): quotient = dividend, remainder = 0.
- Reset (reset==0 at a rising edge), including mid-operation:
  - State→IDLE; counter, accumulator and md_result→0.
  - md_busy, md_done, md_stall→0; no done pulse is produced for an aborted op.
  - aluoperation is unaffected (combinational).

Decomposition:
- Shared package alu_pkg holds:
  - aluop class constants;
  - 4-bit aluoperation codes (including 1000 MD-select, 1001 xor, 1111 invalid);
  - func7 constants (0000000, 0100000, 0000001);
  - M-op func3 enum;
  - FSM state typedef.
- One sub-module, md_iter_core: iterative mul/div datapath (accumulator, counter, FIX correction). The top holds decode, FSM and handshake.

Test Plan:
- MUL with operand_a=7, operand_b=0xFFFFFFFD, WIDTH=32 → md_result=0xFFFFFFEB; md_done exactly 34 cycles after start; md_stall high for 33 cycles.
- MULHU with 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULH with the same operands → 0x00000000; MULHSU with 0xFFFFFFFF, 2 → 0xFFFFFFFF.
- DIV with −7 ÷ 2 → 0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF; DIVU with 5 ÷ 0 → 0xFFFFFFFF; REMU with 5 ÷ 0 → 5; DIV with 0x80000000 ÷ 0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- Abort and ignored start: reset=0 in the 10th CALC cycle → next edge busy=0, stall=0, result=0, no md_done; a start pulse issued while busy leaves the in-flight result unchanged.
- Decode: aluop=111, f3=000, f7=0100000 → 0111; aluop=010 → 0111; aluop=111, f7=0000001 → 1000; aluop=110 → 1111; start with an add op → md_busy stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared constants and types for the ALU control / multiply-divide.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    // aluop classes from the main control unit
    localparam logic [2:0] ALUOP_ADD = 3'b000;
    localparam logic [2:0] ALUOP_AND = 3'b001;
    localparam logic [2:0] ALUOP_BEQ = 3'b010;
    localparam logic [2:0] ALUOP_BNE = 3'b011;
    localparam logic [2:0] ALUOP_LUI = 3'b100;
    localparam logic [2:0] ALUOP_OR  = 3'b101;
    localparam logic [2:0] ALUOP_R   = 3'b111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_LUI = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SUB = 4'b0111;
    localparam logic [3:0] ALU_MD  = 4'b1000;
    localparam logic [3:0] ALU_XOR = 4'b1001;
    localparam logic [3:0] ALU_INV = 4'b1111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_func3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

    function automatic logic md_signed_a(input logic [2:0] f3);
        return (f3 == MD_MUL) || (f3 == MD_MULH) || (f3 == MD_MULHSU) ||
               (f3 == MD_DIV) || (f3 == MD_REM);
    endfunction

    function automatic logic md_signed_b(input logic [2:0] f3);
        return (f3 == MD_MUL) || (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/md_iter_core.sv
// ============================================================================
// Module : md_iter_core
// Brief  : Iterative shift-add multiplier / restoring divider with sign fixup.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module md_iter_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             calc_i,
    input  logic             fix_i,
    input  logic [2:0]       func3_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    output logic             cnt_last_o,
    output logic [WIDTH-1:0] result_o
);

    md_func3_e          op_q;
    logic               neg_a_q, neg_b_q, b_zero_q;
    logic [WIDTH-1:0]   m_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   result_q;

    logic               neg_a_in, neg_b_in, is_div_in;
    logic [WIDTH-1:0]   mag_a_in, mag_b_in;
    logic [WIDTH:0]     mul_sum, div_shift, div_trial;
    logic [2*WIDTH-1:0] acc_step, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fix_result;

    assign is_div_in = func3_i[2];
    assign neg_a_in  = md_signed_a(func3_i) & operand_a_i[WIDTH-1];
    assign neg_b_in  = md_signed_b(func3_i) & operand_b_i[WIDTH-1];
    assign mag_a_in  = neg_a_in ? -operand_a_i : operand_a_i;
    assign mag_b_in  = neg_b_in ? -operand_b_i : operand_b_i;

    // acc holds {high, low}: multiply keeps multiplier in low, divide keeps
    // remainder in high and the dividend shifting out into quotient bits.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, m_q};
        acc_step  = {mul_sum, acc_q[WIDTH-1:1]};
        if (op_q[2]) begin
            if (!div_trial[WIDTH])
                acc_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quo_fix  = b_zero_q ? '1 :
                   ((neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
        rem_fix  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        case (op_q)
            MD_MUL:                      fix_result = prod_fix[WIDTH-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_result = prod_fix[2*WIDTH-1:WIDTH];
            MD_DIV, MD_DIVU:             fix_result = quo_fix;
            default:                     fix_result = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q     <= MD_MUL;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            b_zero_q <= 1'b0;
            m_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            if (load_i) begin
                op_q     <= md_func3_e'(func3_i);
                neg_a_q  <= neg_a_in;
                neg_b_q  <= neg_b_in;
                b_zero_q <= (operand_b_i == '0);
                m_q      <= is_div_in ? mag_b_in : mag_a_in;
                acc_q    <= {{WIDTH{1'b0}}, (is_div_in ? mag_a_in : mag_b_in)};
                cnt_q    <= CNT_W'(WIDTH);
            end else if (calc_i) begin
                acc_q <= acc_step;
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (fix_i)
                result_q <= fix_result;
        end
    end

    assign cnt_last_o = (cnt_q == CNT_W'(1));
    assign result_o   = result_q;

endmodule

`default_nettype wire

// File: rtl/alu_md_control.sv
// ============================================================================
// Module : alu_md_control
// Brief  : ALU operation decode plus RV32M multiply/divide sequencing.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_md_control
    import alu_pkg::*;
#(
    parameter int         WIDTH   = 32,
    parameter int         CNT_W   = $clog2(WIDTH) + 1,
    parameter logic [2:0] R_ALUOP = 3'b111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       aluop,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [3:0]       aluoperation,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] md_result,
    output logic             md_stall
);

    md_state_e state_q, state_d;
    logic      md_op, accept, load, calc, fix, cnt_last;

    always_comb begin
        aluoperation = ALU_INV;
        if (aluop == R_ALUOP) begin
            if (func7 == F7_BASE) begin
                case (func3)
                    3'b000:  aluoperation = ALU_ADD;
                    3'b111:  aluoperation = ALU_AND;
                    3'b110:  aluoperation = ALU_OR;
                    3'b001:  aluoperation = ALU_SLL;
                    3'b101:  aluoperation = ALU_SRL;
                    3'b100:  aluoperation = ALU_XOR;
                    default: aluoperation = ALU_INV;
                endcase
            end else if (func7 == F7_ALT && func3 == 3'b000) begin
                aluoperation = ALU_SUB;
            end else if (func7 == F7_MULDIV) begin
                aluoperation = ALU_MD;
            end
        end else begin
            case (aluop)
                ALUOP_ADD:            aluoperation = ALU_ADD;
                ALUOP_AND:            aluoperation = ALU_AND;
                ALUOP_LUI:            aluoperation = ALU_LUI;
                ALUOP_OR:             aluoperation = ALU_OR;
                ALUOP_BEQ, ALUOP_BNE: aluoperation = ALU_SUB;
                default:              aluoperation = ALU_INV;
            endcase
        end
    end

    assign md_op  = (aluop == R_ALUOP) && (func7 == F7_MULDIV);
    assign accept = (state_q == ST_IDLE) && start && md_op;

    always_ff @(posedge clk) begin
        if (!reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        calc    = 1'b0;
        fix     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                calc = 1'b1;
                if (cnt_last)
                    state_d = ST_FIX;
            end
            ST_FIX: begin
                fix     = 1'b1;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign md_busy  = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign md_done  = (state_q == ST_DONE);
    assign md_stall = accept || md_busy;

    md_iter_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load),
        .calc_i      (calc),
        .fix_i       (fix),
        .func3_i     (func3),
        .operand_a_i (operand_a),
        .operand_b_i (operand_b),
        .cnt_last_o  (cnt_last),
        .result_o    (md_result)
    );

endmodule

`default_nettype wire

// File: tb/tb_alu_md_control.sv
// ============================================================================
// Module : tb_alu_md_control
// Brief  : Directed self-checking bench for alu_md_control (WIDTH=32).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_md_control;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   aluop;
    logic [2:0]   func3;
    logic [6:0]   func7;
    logic         start;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic [3:0]   aluoperation;
    logic         md_busy;
    logic         md_done;
    logic [W-1:0] md_result;
    logic         md_stall;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_md_control #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .aluop        (aluop),
        .func3        (func3),
        .func7        (func7),
        .start        (start),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .aluoperation (aluoperation),
        .md_busy      (md_busy),
        .md_done      (md_done),
        .md_result    (md_result),
        .md_stall     (md_stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic decode_chk(input string tag, input logic [2:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [3:0] exp);
        aluop = op;
        func3 = f3;
        func7 = f7;
        #1;
        check(tag, 32'(aluoperation), 32'(exp));
    endtask

    // Called at a negedge with the engine idle; returns at the negedge after done.
    task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit pulse_mid);
        int done_k;
        int stall_n;
        aluop     = 3'b111;
        func7     = 7'b0000001;
        func3     = f3;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        #1;
        check({tag, " stall_issue"}, 32'(md_stall), 32'd1);
        done_k  = 0;
        stall_n = 0;
        for (int k = 1; k <= 60 && done_k == 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (pulse_mid && k == 5) begin
                start     = 1'b1;
                func3     = 3'b000;
                operand_a = 32'h0000_1234;
                operand_b = 32'h0000_0055;
            end
            if (md_stall) stall_n++;
            if (md_done) done_k = k;
        end
        start = 1'b0;
        check({tag, " result"}, md_result, exp);
        check({tag, " latency"}, 32'(done_k), 32'd34);
        check({tag, " stall_cycles"}, 32'(stall_n), 32'd33);
        @(negedge clk);
        check({tag, " done_pulse"}, {30'd0, md_done, md_busy}, 32'd0);
    endtask

    initial begin
        int dones;
        reset     = 1'b0;
        aluop     = 3'b000;
        func3     = 3'b000;
        func7     = 7'b0000000;
        start     = 1'b0;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {md_result[28:0], md_busy, md_done, md_stall}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        decode_chk("dec_add",   3'b111, 3'b000, 7'b0000000, 4'b0000);
        decode_chk("dec_and",   3'b111, 3'b111, 7'b0000000, 4'b0001);
        decode_chk("dec_xor",   3'b111, 3'b100, 7'b0000000, 4'b1001);
        decode_chk("dec_srl",   3'b111, 3'b101, 7'b0000000, 4'b0110);
        decode_chk("dec_sub",   3'b111, 3'b000, 7'b0100000, 4'b0111);
        decode_chk("dec_alt_bad", 3'b111, 3'b001, 7'b0100000, 4'b1111);
        decode_chk("dec_md",    3'b111, 3'b101, 7'b0000001, 4'b1000);
        decode_chk("dec_beq",   3'b010, 3'b000, 7'b0000000, 4'b0111);
        decode_chk("dec_bne",   3'b011, 3'b000, 7'b0000000, 4'b0111);
        decode_chk("dec_lui",   3'b100, 3'b000, 7'b0000000, 4'b0010);
        decode_chk("dec_ori",   3'b101, 3'b000, 7'b0000000, 4'b0100);
        decode_chk("dec_inv",   3'b110, 3'b000, 7'b0000000, 4'b1111);

        // start on a plain add must not launch the engine
        aluop = 3'b111; func3 = 3'b000; func7 = 7'b0000000; start = 1'b1;
        #1;
        check("add_start_stall", 32'(md_stall), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("add_start_busy", 32'(md_busy), 32'd0);
        @(negedge clk);

        run_md("mul",      3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_md("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_md("mulh",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        run_md("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 1'b0);
        run_md("div",      3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0);
        run_md("rem",      3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0);
        run_md("divu0",    3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 1'b0);
        run_md("remu0",    3'b111, 32'd5,        32'd0,        32'd5,         1'b0);
        run_md("div0_neg", 3'b100, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFFF, 1'b0);
        run_md("rem0_neg", 3'b110, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 1'b0);
        run_md("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        run_md("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0);
        run_md("divu",     3'b101, 32'd100,      32'd7,        32'd14,        1'b0);
        run_md("div_ign",  3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b1);

        // abort in the 10th CALC cycle with a nonzero result held
        aluop = 3'b111; func7 = 7'b0000001; func3 = 3'b000;
        operand_a = 32'd7; operand_b = 32'd9; start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("abort_busy_before", 32'(md_busy), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy",   32'(md_busy),  32'd0);
        check("abort_stall",  32'(md_stall), 32'd0);
        check("abort_done",   32'(md_done),  32'd0);
        check("abort_result", md_result,     32'd0);
        reset = 1'b1;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (md_done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);

        // engine usable again after the abort
        run_md("mul_after", 3'b000, 32'd6, 32'd7, 32'd42, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
